cpu_trace_buffer: RTL

- Synthesizable in-design trace capture for the GameBoy CPU, successor to print-based state monitoring.
- On each instruction-boundary strobe from the control path, samples the architectural state (PC, IR, SP, A B C D E F H L, plus user extra bits) into a parametrised circular buffer.
- Trigger modes: immediate, PC match, opcode match, external.
- After the trigger, captures a programmable number of further samples, then freezes for readout by a bench or debug port.

---
 rtl/gb_trace_pkg.sv | 35 +++
 rtl/cpu_trace_buffer_ram.sv | 26 ++
 rtl/cpu_trace_buffer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/gb_trace_pkg.sv
// Shared types for the GameBoy CPU trace buffer: record layout, FSM states, trigger modes.
package gb_trace_pkg;

  localparam int unsigned REC_W = 104;

  // User EXT bits are appended below l in the sampled word.
  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  ir;
    logic [15:0] sp;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  c;
    logic [7:0]  d;
    logic [7:0]  e;
    logic [7:0]  f;
    logic [7:0]  h;
    logic [7:0]  l;
  } trace_rec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_t;

  typedef enum logic [1:0] {
    TRIG_IMM = 2'd0,
    TRIG_PC  = 2'd1,
    TRIG_IR  = 2'd2,
    TRIG_EXT = 2'd3
  } trig_mode_t;

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// Simple dual-port trace memory: one write port, one registered read port.
module trace_ram #(
  parameter int unsigned AW = 6,
  parameter int unsigned W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/cpu_trace_buffer.sv
// Trigger-based circular capture of CPU architectural state with logical-order readout.
module cpu_trace_buffer
  import gb_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned TS_W  = 16,
  parameter int unsigned EXT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arm,
  input  logic                         disarm,
  input  logic [1:0]                   trig_mode,
  input  logic [15:0]                  trig_pc,
  input  logic [7:0]                   trig_ir,
  input  logic                         ext_trig,
  input  logic [$clog2(DEPTH)-1:0]     post_count,
  input  logic                         sample_valid,
  input  logic [REC_W+EXT_W-1:0]       sample_data,
  output logic [1:0]                   state,
  output logic                         triggered,
  output logic                         done,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         wrapped,
  output logic [$clog2(DEPTH)-1:0]     trig_index,
  input  logic [$clog2(DEPTH)-1:0]     rd_addr,
  output logic [REC_W+EXT_W-1:0]       rd_data,
  output logic [TS_W-1:0]              rd_ts
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = REC_W + EXT_W;
  localparam int unsigned MW = DW + TS_W;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  trace_state_t  st;
  logic [AW-1:0] wp, trig_phys, remaining, base;
  logic [TS_W-1:0] ts;
  logic [15:0]   s_pc;
  logic [7:0]    s_ir;
  logic          capturing, we, hit;
  logic [MW-1:0] rdout;

  assign s_pc      = sample_data[DW-1 -: 16];
  assign s_ir      = sample_data[DW-17 -: 8];
  assign capturing = (st == ARMED) || (st == POST);
  assign we        = sample_valid && capturing && !disarm && !arm && !rst;

  always_comb begin
    hit = 1'b0;
    unique case (trig_mode_t'(trig_mode))
      TRIG_IMM: hit = 1'b1;
      TRIG_PC:  hit = (s_pc == trig_pc);
      TRIG_IR:  hit = (s_ir == trig_ir);
      TRIG_EXT: hit = ext_trig;
    endcase
  end

  // Once wrapped, the oldest entry sits at wp; logical indices are offsets from it.
  assign base       = wrapped ? wp : '0;
  assign trig_index = trig_phys - base;
  assign state      = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      triggered <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      wrapped   <= 1'b0;
      wp        <= '0;
      ts        <= '0;
      trig_phys <= '0;
      remaining <= '0;
    end else if (disarm) begin
      st   <= IDLE;
      done <= 1'b0;
    end else if (arm) begin
      st        <= ARMED;
      done      <= 1'b0;
      triggered <= 1'b0;
      count     <= '0;
      wrapped   <= 1'b0;
      wp        <= '0;
      ts        <= '0;
      trig_phys <= '0;
    end else begin
      if (capturing && ts != '1) ts <= ts + 1'b1;
      if (we) begin
        wp <= wp + 1'b1;
        if (count == FULL) wrapped <= 1'b1;
        else               count   <= count + 1'b1;
        if (st == ARMED) begin
          if (hit) begin
            triggered <= 1'b1;
            trig_phys <= wp;
            if (post_count == '0) begin
              st   <= DONE;
              done <= 1'b1;
            end else begin
              remaining <= post_count;
              st        <= POST;
            end
          end
        end else begin
          remaining <= remaining - 1'b1;
          if (remaining == AW'(1)) begin
            st   <= DONE;
            done <= 1'b1;
          end
        end
      end
    end
  end

  trace_ram #(.AW(AW), .W(MW)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (wp),
    .wdata ({sample_data, ts}),
    .raddr (base + rd_addr),
    .rdata (rdout)
  );

  assign rd_data = rdout[MW-1 -: DW];
  assign rd_ts   = rdout[TS_W-1:0];

endmodule
